// File: rtl/stream_out_arb_fifo.sv
// ---------------------------------------------------------------------------
// stream_out_arb_fifo
//
// Merges N_CH per-core output streams into a single AXI-Stream-like link.
// A packet-atomic arbiter (round-robin or fixed priority, channel 0 highest)
// picks one eligible channel at a time.  Beats then pass through a DEPTH-entry
// synchronous FIFO so that the link toward the FPGA starts from registers.
//
// Optional feature macro: STREAM_OUT_TAG_EN
//   defined   -> every FIFO entry also stores the source channel id, and the
//                id is presented on m_id.
//   undefined -> m_id port is absent; entries hold {last, data} only.
//
// Ports
//   clk          rising-edge clock
//   resetb       asynchronous active-low reset
//   s_valid      per-channel beat valid
//   s_ready      per-channel ready (one-hot or zero)
//   s_last       per-channel end-of-packet
//   s_data       channel i on bits [i*DATA_W +: DATA_W]
//   access_core  per-channel eligibility mask for new grants
//   detected     registered: some eligible channel is asserting valid
//   m_valid      output beat valid (FIFO not empty)
//   m_ready      downstream ready
//   m_last       end-of-packet of the current output beat
//   m_data       output beat
//   m_id         source channel of m_data (STREAM_OUT_TAG_EN only)
//   fifo_level   FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module stream_out_arb_fifo #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ARB_RR = 1,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic [N_CH-1:0]          s_valid,
    output logic [N_CH-1:0]          s_ready,
    input  logic [N_CH-1:0]          s_last,
    input  logic [N_CH*DATA_W-1:0]   s_data,
    input  logic [N_CH-1:0]          access_core,
    output logic                     detected,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [DATA_W-1:0]        m_data,
`ifdef STREAM_OUT_TAG_EN
    output logic [CH_W-1:0]          m_id,
`endif
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
`ifdef STREAM_OUT_TAG_EN
    localparam int FW = CH_W + 1 + DATA_W;
`else
    localparam int FW = 1 + DATA_W;
`endif

    typedef enum logic {IDLE, PKT} state_t;

    state_t              state;
    logic [CH_W-1:0]     grant;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     winner;
    logic [CH_W-1:0]     sel;
    logic                found;
    logic [N_CH-1:0]     req;
    logic [DATA_W-1:0]   ch_data [N_CH];
    logic                push;
    logic                pop;
    logic                push_last;
    logic [DATA_W-1:0]   push_data;
    logic [FW-1:0]       push_word;
    logic [FW-1:0]       head_word;
    logic [FW-1:0]       hold_word;
    logic [FW-1:0]       out_word;
    logic [FW-1:0]       mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic                full;
    logic                empty;

    // Next round-robin start position after channel c, wrapping to 0.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        if (int'(c) >= N_CH - 1)
            return '0;
        return CH_W'(int'(c) + 1);
    endfunction

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = s_data[i*DATA_W +: DATA_W];
    end

    assign req = s_valid & access_core;

    // Winner search: the scan starts at rr_ptr for round-robin or at 0 for
    // fixed priority, and the first requesting channel wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (ARB_RR != 0) ? int'(rr_ptr) + k : k;
            if (idx >= N_CH)
                idx = idx - N_CH;
            if (!found && req[CH_W'(idx)]) begin
                found  = 1'b1;
                winner = CH_W'(idx);
            end
        end
    end

    // The grant is combinational in IDLE so the winner's first beat is taken
    // in the grant cycle.  Ready is forced low while reset is asserted.
    always_comb begin
        s_ready = '0;
        if (resetb) begin
            if (state == PKT)
                s_ready[grant] = !full;
            else if (found && !full)
                s_ready[winner] = 1'b1;
        end
    end

    assign sel       = (state == IDLE) ? winner : grant;
    assign push      = |(s_valid & s_ready);
    assign push_last = s_last[sel];
    assign push_data = ch_data[sel];
`ifdef STREAM_OUT_TAG_EN
    assign push_word = {sel, push_last, push_data};
`else
    assign push_word = {push_last, push_data};
`endif

    // Packet FSM.  A single-beat packet finishes in its grant cycle and never
    // leaves IDLE; otherwise the owner keeps the link until its last beat,
    // regardless of later changes to access_core or s_valid.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        grant <= winner;
                        if (push_last)
                            rr_ptr <= next_ch(winner);
                        else
                            state <= PKT;
                    end
                end
                PKT: begin
                    if (push && push_last) begin
                        state  <= IDLE;
                        rr_ptr <= next_ch(grant);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage carries no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= push_word;
    end

    // Pointers, plus a copy of the last popped entry so the outputs hold
    // their previous values once the FIFO runs empty.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold_word <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                hold_word <= head_word;
            end
        end
    end

    // Activity flag sampled every cycle, independent of FIFO state.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            detected <= 1'b0;
        else
            detected <= |req;
    end

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_level = wr_ptr - rd_ptr;
    assign head_word  = mem[rd_ptr[AW-1:0]];
    assign out_word   = empty ? hold_word : head_word;
    assign m_valid    = !empty;
    assign pop        = m_valid && m_ready;
    assign m_data     = out_word[DATA_W-1:0];
    assign m_last     = out_word[DATA_W];
`ifdef STREAM_OUT_TAG_EN
    assign m_id       = out_word[FW-1 -: CH_W];
`endif

endmodule

// File: tb/tb_stream_out_arb_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_out_arb_fifo
//
// Directed bench for stream_out_arb_fifo with default parameters
// (4 channels, 32-bit data, 8-entry FIFO, round-robin).  Inputs change on the
// falling edge; outputs are sampled on the falling edge or just after it.
// ---------------------------------------------------------------------------
module tb_stream_out_arb_fifo;

    localparam int N_CH   = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;

    logic                   clk = 1'b0;
    logic                   resetb;
    logic [N_CH-1:0]        s_valid;
    logic [N_CH-1:0]        s_ready;
    logic [N_CH-1:0]        s_last;
    logic [N_CH*DATA_W-1:0] s_data;
    logic [N_CH-1:0]        access_core;
    logic                   detected;
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_last;
    logic [DATA_W-1:0]      m_data;
`ifdef STREAM_OUT_TAG_EN
    logic [1:0]             m_id;
`endif
    logic [3:0]             fifo_level;

    int errors = 0;
    int checks = 0;

    int          k;
    int          nOut;
    logic        multi;
    logic [3:0]  acc;
    logic [31:0] obs [16];
    logic [32:0] obsBp [16];
    logic [7:0]  expRr [10];
    int          beatCnt [4];
    int          pktCnt [4];

    stream_out_arb_fifo #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ARB_RR (1)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_last      (s_last),
        .s_data      (s_data),
        .access_core (access_core),
        .detected    (detected),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .m_data      (m_data),
`ifdef STREAM_OUT_TAG_EN
        .m_id        (m_id),
`endif
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearStimulus();
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
    endtask

    task automatic applyStimulus(input logic [1:0] ch, input logic [31:0] data, input logic last);
        s_valid[ch] = 1'b1;
        s_last[ch]  = last;
        s_data[{ch, 5'd0} +: 32] = data;
    endtask

    task automatic resetDut();
        resetb = 1'b0;
        clearStimulus();
        access_core = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
    endtask

    initial begin
        expRr = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd0, 8'd0};

        // Reset state
        resetb = 1'b0;
        clearStimulus();
        access_core = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_s_ready", 64'(s_ready), 64'(0));
        checkOutput("rst_detected", 64'(detected), 64'(0));
        checkOutput("rst_m_valid", 64'(m_valid), 64'(0));
        checkOutput("rst_m_data", 64'(m_data), 64'(0));
        checkOutput("rst_m_last", 64'(m_last), 64'(0));
        checkOutput("rst_level", 64'(fifo_level), 64'(0));
        resetb = 1'b1;

        // Single beat on channel 2
        access_core = 4'hF;
        applyStimulus(2'd2, 32'hA5A5_0001, 1'b1);
        #1;
        checkOutput("single_ready", 64'(s_ready), 64'(4'b0100));
        @(negedge clk);
        clearStimulus();
        checkOutput("single_valid", 64'(m_valid), 64'(1));
        checkOutput("single_data", 64'(m_data), 64'(32'hA5A5_0001));
        checkOutput("single_last", 64'(m_last), 64'(1));
        checkOutput("single_level", 64'(fifo_level), 64'(1));
        checkOutput("single_detected", 64'(detected), 64'(1));
`ifdef STREAM_OUT_TAG_EN
        checkOutput("single_id", 64'(m_id), 64'(2));
`endif
        m_ready = 1'b1;
        @(negedge clk);
        checkOutput("single_empty", 64'(m_valid), 64'(0));
        checkOutput("single_hold", 64'({m_last, m_data}), 64'({1'b1, 32'hA5A5_0001}));
        checkOutput("single_level0", 64'(fifo_level), 64'(0));

        // Round-robin fairness with continuous 2-beat packets on all channels
        resetDut();
        m_ready = 1'b1;
        access_core = 4'hF;
        nOut = 0;
        multi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beatCnt[2'(i)] = 0;
            pktCnt[2'(i)]  = 0;
        end
        for (int cyc = 0; cyc < 60 && nOut < 10; cyc++) begin
            @(negedge clk);
            if (m_valid) begin
                obs[4'(nOut)] = m_data;
                nOut++;
            end
            for (int i = 0; i < 4; i++)
                applyStimulus(2'(i), (32'(i) << 24) | (32'(pktCnt[2'(i)]) << 8) | 32'(beatCnt[2'(i)]),
                              beatCnt[2'(i)] == 1);
            #1;
            acc = s_valid & s_ready;
            if ((acc & (acc - 4'd1)) != 4'd0)
                multi = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (acc[2'(i)]) begin
                    if (beatCnt[2'(i)] == 1) begin
                        beatCnt[2'(i)] = 0;
                        pktCnt[2'(i)]++;
                    end else begin
                        beatCnt[2'(i)] = 1;
                    end
                end
            end
        end
        checkOutput("rr_count", 64'(nOut), 64'(10));
        checkOutput("rr_onehot", 64'(multi), 64'(0));
        for (int i = 0; i < 10 && i < nOut; i++)
            checkOutput($sformatf("rr_beat%0d", i),
                        64'({obs[4'(i)][31:24], obs[4'(i)][7:0]}),
                        64'({expRr[4'(i)], 8'(i % 2)}));

        // Access mask blocks a requesting channel until it is enabled
        resetDut();
        m_ready = 1'b1;
        access_core = 4'b1101;
        @(negedge clk);
        applyStimulus(2'd1, 32'h1111_0001, 1'b1);
        #1;
        checkOutput("mask_ready", 64'(s_ready), 64'(0));
        @(negedge clk);
        checkOutput("mask_detected", 64'(detected), 64'(0));
        checkOutput("mask_level", 64'(fifo_level), 64'(0));
        access_core = 4'hF;
        #1;
        checkOutput("mask_grant", 64'(s_ready), 64'(4'b0010));
        @(negedge clk);
        clearStimulus();
        checkOutput("mask_detected1", 64'(detected), 64'(1));
        checkOutput("mask_out", 64'({m_valid, m_data}), 64'({1'b1, 32'h1111_0001}));

        // Backpressure: 12-beat packet into an 8-entry FIFO
        resetDut();
        access_core = 4'hF;
        m_ready = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            applyStimulus(2'd0, 32'hB000_0000 + 32'(k), k == 11);
            #1;
            if (s_ready[0]) k++;
        end
        @(negedge clk);
        applyStimulus(2'd0, 32'hB000_0000 + 32'(k), k == 11);
        #1;
        checkOutput("bp_accepted", 64'(k), 64'(8));
        checkOutput("bp_level", 64'(fifo_level), 64'(8));
        checkOutput("bp_ready", 64'(s_ready), 64'(0));
        checkOutput("bp_stall_out", 64'({m_valid, m_last, m_data}), 64'({1'b1, 1'b0, 32'hB000_0000}));
        nOut = 0;
        for (int cyc = 0; cyc < 60 && nOut < 12; cyc++) begin
            @(negedge clk);
            m_ready = 1'b1;
            if (m_valid) begin
                obsBp[4'(nOut)] = {m_last, m_data};
                nOut++;
            end
            if (k < 12)
                applyStimulus(2'd0, 32'hB000_0000 + 32'(k), k == 11);
            else
                clearStimulus();
            #1;
            if (k < 12 && s_ready[0]) k++;
        end
        clearStimulus();
        checkOutput("bp_out_count", 64'(nOut), 64'(12));
        for (int i = 0; i < 12 && i < nOut; i++)
            checkOutput($sformatf("bp_beat%0d", i), 64'(obsBp[4'(i)]),
                        64'({i == 11, 32'hB000_0000 + 32'(i)}));
        @(negedge clk);
        checkOutput("bp_level0", 64'(fifo_level), 64'(0));

        // Mask cleared after the first beat of a 4-beat packet
        resetDut();
        m_ready = 1'b1;
        access_core = 4'hF;
        k = 0;
        nOut = 0;
        for (int cyc = 0; cyc < 10 && k < 4; cyc++) begin
            @(negedge clk);
            if (m_valid) nOut++;
            applyStimulus(2'd1, 32'hC000_0000 + 32'(k), k == 3);
            if (k >= 1) access_core = 4'b1101;
            #1;
            if (s_ready[1]) k++;
        end
        checkOutput("drop_accepted", 64'(k), 64'(4));
        @(negedge clk);
        if (m_valid) nOut++;
        applyStimulus(2'd1, 32'hC000_0010, 1'b1);
        #1;
        checkOutput("drop_no_regrant", 64'(s_ready), 64'(0));
        @(negedge clk);
        if (m_valid) nOut++;
        checkOutput("drop_out_count", 64'(nOut), 64'(4));
        checkOutput("drop_detected", 64'(detected), 64'(0));
        clearStimulus();

        // Reset with three beats of a packet buffered
        resetDut();
        m_ready = 1'b0;
        access_core = 4'hF;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            applyStimulus(2'd2, 32'hD000_0000 + 32'(cyc), 1'b0);
        end
        @(negedge clk);
        checkOutput("rstpkt_level3", 64'(fifo_level), 64'(3));
        resetb = 1'b0;
        #1;
        checkOutput("rstpkt_m_valid", 64'(m_valid), 64'(0));
        checkOutput("rstpkt_level", 64'(fifo_level), 64'(0));
        checkOutput("rstpkt_ready", 64'(s_ready), 64'(0));
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
        clearStimulus();
        applyStimulus(2'd0, 32'hE000_0001, 1'b1);
        applyStimulus(2'd2, 32'hD000_0003, 1'b0);
        #1;
        checkOutput("rstpkt_idle_grant", 64'(s_ready), 64'(4'b0001));
        @(negedge clk);
        clearStimulus();
        checkOutput("rstpkt_out", 64'({m_valid, m_last, m_data}), 64'({1'b1, 1'b1, 32'hE000_0001}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
